// File: rtl/wb_axi_write_arbiter.sv
// Shares one AXI write channel between uncached single-word stores and write-buffer line drains.
// A grant is followed by AW, then W beats, then B; the winner gets a one-cycle done pulse on the B handshake.
module wb_axi_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         unc_req_i,
  input  logic [31:0]  unc_addr_i,
  input  logic [31:0]  unc_data_i,
  input  logic [3:0]   unc_strb_i,
  output logic         unc_done_o,
  input  logic         wb_req_i,
  input  logic [31:0]  wb_addr_i,
  input  logic [127:0] wb_data_i,
  output logic         wb_done_o,
  output logic         bus_err_o,
  output logic         busy_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic [1:0]   bresp_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, TURN} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t          state_q, state_d;
  logic            owner_wb_q;
  logic [1:0]      beat_q;
  logic [3:0][31:0] line_q;
  logic [3:0]      starve_q;
  logic [31:0]     awaddr_q;
  logic [7:0]      awlen_q;
  logic [2:0]      awsize_q;
  logic [1:0]      awburst_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;

  logic grant, grant_wb, same_line, starved, w_hs, b_hs, last_beat;
  logic [1:0] beat_nxt;
  logic unused_addr_bits;

  assign unused_addr_bits = ^wb_addr_i[3:0];

  // Same-line conflict sends the line first so the uncached store lands after it.
  assign same_line = unc_req_i && wb_req_i && (unc_addr_i[31:4] == wb_addr_i[31:4]);
  assign starved   = wb_req_i && (starve_q == LIMIT);
  assign grant_wb  = same_line || starved || (wb_req_i && !unc_req_i);
  assign grant     = (state_q == IDLE) && (unc_req_i || wb_req_i);
  assign last_beat = (beat_q == awlen_q[1:0]);
  assign beat_nxt  = beat_q + 2'd1;
  assign w_hs      = (state_q == DATA) && wready_i;
  assign b_hs      = (state_q == RESP) && bvalid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ADDR;
      ADDR:    if (awready_i) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (bvalid_i) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_wb_q <= 1'b0;
      beat_q     <= 2'd0;
      line_q     <= '0;
      starve_q   <= 4'd0;
      awaddr_q   <= 32'd0;
      awlen_q    <= 8'd0;
      awsize_q   <= 3'd0;
      awburst_q  <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_wb_q <= grant_wb;
        beat_q     <= 2'd0;
        awsize_q   <= 3'b010;
        awburst_q  <= 2'b01;
        awaddr_q   <= grant_wb ? {wb_addr_i[31:4], 4'b0000} : unc_addr_i;
        awlen_q    <= grant_wb ? 8'd3 : 8'd0;
        line_q     <= grant_wb ? wb_data_i : {96'd0, unc_data_i};
        wdata_q    <= grant_wb ? wb_data_i[31:0] : unc_data_i;
        wstrb_q    <= grant_wb ? 4'hF : unc_strb_i;
      end else if (w_hs && !last_beat) begin
        beat_q  <= beat_nxt;
        wdata_q <= line_q[beat_nxt];
      end
      // Saturating count of uncached wins taken while a drain waits.
      if (grant) begin
        if (grant_wb || !wb_req_i) starve_q <= 4'd0;
        else if (starve_q < LIMIT) starve_q <= starve_q + 4'd1;
      end else if (state_q == IDLE && !wb_req_i) begin
        starve_q <= 4'd0;
      end
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign awvalid_o  = (state_q == ADDR);
  assign wvalid_o   = (state_q == DATA);
  assign wlast_o    = (state_q == DATA) && last_beat;
  assign bready_o   = (state_q == RESP);
  assign unc_done_o = b_hs && !owner_wb_q;
  assign wb_done_o  = b_hs && owner_wb_q;
  assign bus_err_o  = b_hs && (bresp_i != 2'b00);
  assign awaddr_o   = awaddr_q;
  assign awlen_o    = awlen_q;
  assign awsize_o   = awsize_q;
  assign awburst_o  = awburst_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;

endmodule

// File: tb/tb_wb_axi_write_arbiter.sv
// Scoreboard bench for wb_axi_write_arbiter: directed requests push expected AW/W/B traffic,
// a negedge monitor pops and compares whenever the DUT handshakes.
module tb_wb_axi_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         unc_req_i, unc_done_o, wb_req_i, wb_done_o, bus_err_o, busy_o;
  logic [31:0]  unc_addr_i, unc_data_i, wb_addr_i;
  logic [3:0]   unc_strb_i;
  logic [127:0] wb_data_i;
  logic [31:0]  awaddr_o, wdata_o;
  logic [7:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o, bresp_i;
  logic         awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [3:0]   wstrb_o;

  wb_axi_write_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .unc_req_i(unc_req_i), .unc_addr_i(unc_addr_i), .unc_data_i(unc_data_i),
    .unc_strb_i(unc_strb_i), .unc_done_o(unc_done_o),
    .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_done_o(wb_done_o),
    .bus_err_o(bus_err_o), .busy_o(busy_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct { logic unc; logic wb; logic err; int lat; } b_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  b_t  exp_b[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int w_hs_cnt = 0;

  int aw_delay = 0, b_delay = 0;
  bit w_toggle = 0;
  logic [1:0] resp_cfg = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: configurable AW/B wait states and toggling W ready.
  initial begin
    int aw_cnt, b_cnt;
    aw_cnt = 0; b_cnt = 0;
    awready_i = 0; wready_i = 1; bvalid_i = 0; bresp_i = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        awready_i = 0; bvalid_i = 0; aw_cnt = 0; b_cnt = 0;
      end else begin
        if (awvalid_o && !awready_i) begin
          if (aw_cnt >= aw_delay) begin awready_i = 1; aw_cnt = 0; end
          else aw_cnt++;
        end else awready_i = 0;
        if (w_toggle) wready_i = wvalid_o ? ~wready_i : 1'b0;
        else          wready_i = 1'b1;
        if (bready_o && !bvalid_i) begin
          if (b_cnt >= b_delay) begin bvalid_i = 1; bresp_i = resp_cfg; b_cnt = 0; end
          else b_cnt++;
        end else begin
          bvalid_i = 0; bresp_i = 2'b00;
        end
      end
    end
  end

  // Monitor
  bit          aw_seen = 0;
  int          aw_start = 0;
  bit          w_held = 0;
  logic [31:0] held_data;
  logic [3:0]  held_strb;
  logic        held_last;
  int          busy_chk = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid_o) chk("aw_w_overlap", wvalid_o, 1'b0);
      if (awvalid_o && !aw_seen) begin aw_seen = 1; aw_start = cyc; end
      if (awvalid_o && awready_i) begin
        aw_seen = 0;
        chk("aw_expected", exp_aw.size() > 0, 1'b1);
        if (exp_aw.size() > 0) begin
          aw_t e;
          e = exp_aw.pop_front();
          chk("awaddr", awaddr_o, e.addr);
          chk("awlen", awlen_o, e.len);
          chk("awsize", awsize_o, 3'b010);
          chk("awburst", awburst_o, 2'b01);
        end
      end
      if (w_held) begin
        chk("wvalid_held", wvalid_o, 1'b1);
        chk("wdata_stable", {wdata_o, wstrb_o, wlast_o}, {held_data, held_strb, held_last});
        w_held = 0;
      end
      if (wvalid_o && !wready_i) begin
        w_held = 1; held_data = wdata_o; held_strb = wstrb_o; held_last = wlast_o;
      end
      if (wvalid_o && wready_i) begin
        w_hs_cnt++;
        chk("w_expected", exp_w.size() > 0, 1'b1);
        if (exp_w.size() > 0) begin
          w_t e;
          e = exp_w.pop_front();
          chk("wdata", wdata_o, e.data);
          chk("wstrb", wstrb_o, e.strb);
          chk("wlast", wlast_o, e.last);
        end
      end
      if (unc_done_o || wb_done_o || bus_err_o) begin
        chk("done_expected", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) begin
          b_t e;
          e = exp_b.pop_front();
          chk("done_flags", {unc_done_o, wb_done_o, bus_err_o}, {e.unc, e.wb, e.err});
          if (e.lat >= 0) chk("done_latency", cyc - aw_start, e.lat);
        end
        busy_chk = cyc + 2;
      end
      if (busy_chk >= 0 && cyc == busy_chk - 1) chk("busy_in_turn", busy_o, 1'b1);
      if (busy_chk >= 0 && cyc == busy_chk) begin
        chk("busy_after_done", busy_o, 1'b0);
        busy_chk = -1;
      end
    end
  end

  task automatic push_unc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lat);
    exp_aw.push_back('{a, 8'd0});
    exp_w.push_back('{d, s, 1'b1});
    exp_b.push_back('{1'b1, 1'b0, 1'b0, lat});
  endtask

  task automatic push_wb(input logic [31:0] a, input logic [127:0] d, input logic err, input int lat);
    exp_aw.push_back('{a, 8'd3});
    for (int i = 0; i < 4; i++) exp_w.push_back('{d[i*32 +: 32], 4'hF, (i == 3)});
    exp_b.push_back('{1'b0, 1'b1, err, lat});
  endtask

  task automatic do_unc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 0;
    unc_addr_i = a; unc_data_i = d; unc_strb_i = s; unc_req_i = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (unc_done_o) begin got = 1; break; end
    end
    if (!got) chk("unc_done_timeout", got, 1'b1);
    @(posedge clk); #1;
    unc_req_i = 0;
  endtask

  task automatic do_wb(input logic [31:0] a, input logic [127:0] d);
    bit got;
    got = 0;
    wb_addr_i = a; wb_data_i = d; wb_req_i = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_done_o) begin got = 1; break; end
    end
    if (!got) chk("wb_done_timeout", got, 1'b1);
    @(posedge clk); #1;
    wb_req_i = 0;
  endtask

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
  localparam logic [127:0] LINE_C = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

  initial begin
    int base;
    bit reached;
    rst = 1;
    unc_req_i = 0; unc_addr_i = 0; unc_data_i = 0; unc_strb_i = 0;
    wb_req_i = 0; wb_addr_i = 0; wb_data_i = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valids", {awvalid_o, wvalid_o, wlast_o, bready_o}, 4'b0);
    chk("rst_done", {unc_done_o, wb_done_o, bus_err_o}, 3'b0);
    chk("rst_payload", {awaddr_o, awlen_o, awsize_o, awburst_o, wdata_o, wstrb_o}, 81'd0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk); #1;

    // Single uncached store, zero-wait slave
    push_unc(32'h1FAF_0004, 32'hDEAD_BEEF, 4'b0011, 2);
    do_unc(32'h1FAF_0004, 32'hDEAD_BEEF, 4'b0011);

    // Line drain, low address bits ignored
    push_wb(32'h0000_1230, LINE_A, 1'b0, 5);
    do_wb(32'h0000_1234, LINE_A);

    // Backpressure on all three channels
    aw_delay = 3; w_toggle = 1; b_delay = 5;
    push_wb(32'h0000_4000, LINE_B, 1'b0, -1);
    do_wb(32'h0000_4008, LINE_B);
    push_unc(32'h0000_4100, 32'h1234_5678, 4'b1100, -1);
    do_unc(32'h0000_4100, 32'h1234_5678, 4'b1100);
    aw_delay = 0; w_toggle = 0; b_delay = 0;

    // Same line: drain goes first
    push_wb(32'h0000_1000, LINE_C, 1'b0, 5);
    push_unc(32'h0000_100C, 32'h0BAD_F00D, 4'b1111, 2);
    fork
      do_wb(32'h0000_1000, LINE_C);
      do_unc(32'h0000_100C, 32'h0BAD_F00D, 4'b1111);
    join

    // Different lines: uncached goes first
    push_unc(32'h0000_5000, 32'h5555_0000, 4'b0001, 2);
    push_wb(32'h0000_6000, LINE_A, 1'b0, 5);
    fork
      do_wb(32'h0000_6000, LINE_A);
      do_unc(32'h0000_5000, 32'h5555_0000, 4'b0001);
    join

    // Starvation with limit 2: unc, unc, wb, unc, unc, wb
    push_unc(32'h0000_3000, 32'h3000_0000, 4'hF, 2);
    push_unc(32'h0000_3004, 32'h3000_0001, 4'hF, 2);
    push_wb(32'h0000_2000, LINE_B, 1'b0, 5);
    push_unc(32'h0000_3008, 32'h3000_0002, 4'hF, 2);
    push_unc(32'h0000_300C, 32'h3000_0003, 4'hF, 2);
    push_wb(32'h0000_2000, LINE_C, 1'b0, 5);
    fork
      begin
        do_wb(32'h0000_2000, LINE_B);
        do_wb(32'h0000_2000, LINE_C);
      end
      begin
        do_unc(32'h0000_3000, 32'h3000_0000, 4'hF);
        do_unc(32'h0000_3004, 32'h3000_0001, 4'hF);
        do_unc(32'h0000_3008, 32'h3000_0002, 4'hF);
        do_unc(32'h0000_300C, 32'h3000_0003, 4'hF);
      end
    join

    // Error response on a drain
    resp_cfg = 2'b10;
    push_wb(32'h0000_8000, LINE_A, 1'b1, 5);
    do_wb(32'h0000_8000, LINE_A);
    resp_cfg = 2'b00;

    // Reset while beat 2 of a drain is on the bus
    exp_aw.push_back('{32'h0000_7000, 8'd3});
    exp_w.push_back('{LINE_B[31:0], 4'hF, 1'b0});
    exp_w.push_back('{LINE_B[63:32], 4'hF, 1'b0});
    base = w_hs_cnt;
    reached = 0;
    wb_addr_i = 32'h0000_7000; wb_data_i = LINE_B; wb_req_i = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (w_hs_cnt == base + 2) begin reached = 1; break; end
    end
    if (!reached) chk("reset_setup_timeout", reached, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_valids", {awvalid_o, wvalid_o, wlast_o, bready_o, busy_o}, 5'b0);
    chk("midrst_done", {unc_done_o, wb_done_o, bus_err_o}, 3'b0);
    chk("midrst_payload", {awaddr_o, awlen_o, wdata_o, wstrb_o}, 76'd0);
    wb_req_i = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy_o, 1'b0);

    // Recovery after reset
    push_unc(32'h0000_9000, 32'h9999_9999, 4'b0101, 2);
    do_unc(32'h0000_9000, 32'h9999_9999, 4'b0101);

    repeat (10) @(posedge clk);
    #1;
    chk("aw_queue_empty", exp_aw.size(), 0);
    chk("w_queue_empty", exp_w.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
